// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the SRAM arbiter and its optional statistics block.
package sram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } arb_state_t;

    typedef enum logic {
        PORT_CPU,
        PORT_DBG
    } port_id_t;

    localparam logic STROBE_OFF = 1'b1;

endpackage

// File: rtl/sram_arbiter_sat_counter.sv
// Saturating event counter with synchronous clear; clear wins over increment.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/sram_arbiter.sv
// Two-port (CPU / debug) round-robin arbiter for a single async 16-bit SRAM.
// Define ARB_STATS_EN to add grant/conflict counters and the stats_clr input.
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W        = 20,
    parameter int DATA_W        = 16,
    parameter int ACCESS_CYCLES = 2
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_done,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              dbg_done,
    input  logic [DATA_W-1:0] sram_rdata,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    output logic              sram_drive,
    output logic              Mem_CE,
    output logic              Mem_UB,
    output logic              Mem_LB,
    output logic              Mem_OE,
    output logic              Mem_WE
`ifdef ARB_STATS_EN
    ,
    input  logic              stats_clr,
    output logic [15:0]       cpu_grants,
    output logic [15:0]       dbg_grants,
    output logic [15:0]       conflicts
`endif
);

    localparam int CNT_W = 4;

    arb_state_t        state_q, state_d;
    port_id_t          last_q, last_d;
    port_id_t          win_q, win_d;
    logic              we_q, we_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        win_d       = win_q;
        we_d        = we_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cpu_rdata_d = cpu_rdata_q;
        dbg_rdata_d = dbg_rdata_q;
        unique case (state_q)
            IDLE: begin
                if (cpu_req || dbg_req) begin
                    // On a tie the port that was not served last goes first.
                    if (cpu_req && dbg_req) begin
                        win_d = (last_q == PORT_DBG) ? PORT_CPU : PORT_DBG;
                    end else begin
                        win_d = cpu_req ? PORT_CPU : PORT_DBG;
                    end
                    we_d    = (win_d == PORT_CPU) ? cpu_we    : dbg_we;
                    addr_d  = (win_d == PORT_CPU) ? cpu_addr  : dbg_addr;
                    wdata_d = (win_d == PORT_CPU) ? cpu_wdata : dbg_wdata;
                    cnt_d   = CNT_W'(ACCESS_CYCLES - 1);
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt_q == '0) begin
                    state_d = DONE;
                    if (!we_q) begin
                        if (win_q == PORT_CPU) begin
                            cpu_rdata_d = sram_rdata;
                        end else begin
                            dbg_rdata_d = sram_rdata;
                        end
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE: begin
                last_d  = win_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= IDLE;
            last_q      <= PORT_DBG;
            win_q       <= PORT_CPU;
            we_q        <= 1'b0;
            cnt_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cpu_rdata_q <= '0;
            dbg_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            win_q       <= win_d;
            we_q        <= we_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cpu_rdata_q <= cpu_rdata_d;
            dbg_rdata_q <= dbg_rdata_d;
        end
    end

    // Strobes decode straight from registered state, so they are glitch-free per access.
    always_comb begin
        Mem_CE     = STROBE_OFF;
        Mem_UB     = STROBE_OFF;
        Mem_LB     = STROBE_OFF;
        Mem_OE     = STROBE_OFF;
        Mem_WE     = STROBE_OFF;
        sram_drive = 1'b0;
        if (state_q == ACCESS) begin
            Mem_CE = ~STROBE_OFF;
            Mem_UB = ~STROBE_OFF;
            Mem_LB = ~STROBE_OFF;
            if (we_q) begin
                Mem_WE     = ~STROBE_OFF;
                sram_drive = 1'b1;
            end else begin
                Mem_OE = ~STROBE_OFF;
            end
        end
    end

    assign cpu_done   = (state_q == DONE) && (win_q == PORT_CPU);
    assign dbg_done   = (state_q == DONE) && (win_q == PORT_DBG);
    assign cpu_rdata  = cpu_rdata_q;
    assign dbg_rdata  = dbg_rdata_q;
    assign sram_addr  = addr_q;
    assign sram_wdata = wdata_q;

`ifdef ARB_STATS_EN
    sat_counter #(.WIDTH(16)) u_cpu_grants (
        .Clk   (Clk),
        .Reset (Reset),
        .clr   (stats_clr),
        .inc   (cpu_done),
        .count (cpu_grants)
    );

    sat_counter #(.WIDTH(16)) u_dbg_grants (
        .Clk   (Clk),
        .Reset (Reset),
        .clr   (stats_clr),
        .inc   (dbg_done),
        .count (dbg_grants)
    );

    sat_counter #(.WIDTH(16)) u_conflicts (
        .Clk   (Clk),
        .Reset (Reset),
        .clr   (stats_clr),
        .inc   ((state_q == IDLE) && cpu_req && dbg_req),
        .count (conflicts)
    );
`endif

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: SRAM model, reference memory and randomized traffic.
module tb_sram_arbiter;

    localparam int AW = 20;
    localparam int DW = 16;
    localparam int AC = 2;

    logic          Clk = 1'b0;
    logic          Reset;
    logic          cpu_req, cpu_we, dbg_req, dbg_we;
    logic [AW-1:0] cpu_addr, dbg_addr, sram_addr;
    logic [DW-1:0] cpu_wdata, dbg_wdata, cpu_rdata, dbg_rdata;
    logic          cpu_done, dbg_done;
    logic [DW-1:0] sram_rdata, sram_wdata;
    logic          sram_drive, Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE;
`ifdef ARB_STATS_EN
    logic          stats_clr;
    logic [15:0]   cpu_grants, dbg_grants, conflicts;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [DW-1:0] mem     [0:255];
    logic [DW-1:0] ref_mem [0:255];
    logic [DW-1:0] exp_cpu_rd, exp_dbg_rd;
    logic          bd_we;
    logic [7:0]    bd_addr;
    logic [DW-1:0] bd_data;

    always #5 Clk = ~Clk;

    sram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ACCESS_CYCLES(AC)) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_rdata  (cpu_rdata),
        .cpu_done   (cpu_done),
        .dbg_req    (dbg_req),
        .dbg_we     (dbg_we),
        .dbg_addr   (dbg_addr),
        .dbg_wdata  (dbg_wdata),
        .dbg_rdata  (dbg_rdata),
        .dbg_done   (dbg_done),
        .sram_rdata (sram_rdata),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_drive (sram_drive),
        .Mem_CE     (Mem_CE),
        .Mem_UB     (Mem_UB),
        .Mem_LB     (Mem_LB),
        .Mem_OE     (Mem_OE),
        .Mem_WE     (Mem_WE)
`ifdef ARB_STATS_EN
        ,
        .stats_clr  (stats_clr),
        .cpu_grants (cpu_grants),
        .dbg_grants (dbg_grants),
        .conflicts  (conflicts)
`endif
    );

    // Asynchronous SRAM: read data appears while OE/CE are low, write lands while WE/CE are low.
    assign sram_rdata = (!Mem_OE && !Mem_CE) ? mem[sram_addr[7:0]] : 16'hDEAD;

    always @(posedge Clk) begin
        if (bd_we) begin
            mem[bd_addr] <= bd_data;
        end else if (!Mem_WE && !Mem_CE && sram_drive) begin
            mem[sram_addr[7:0]] <= sram_wdata;
        end
    end

    task automatic backdoor(input logic [7:0] a, input logic [DW-1:0] d);
        bd_we = 1'b1; bd_addr = a; bd_data = d; ref_mem[a] = d;
        @(posedge Clk); @(negedge Clk);
        bd_we = 1'b0;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        @(posedge Clk); @(negedge Clk);
        @(posedge Clk); @(negedge Clk);
        Reset = 1'b0;
        exp_cpu_rd = '0;
        exp_dbg_rd = '0;
    endtask

    // Runs one solo access from a negedge; reports done cycle, strobe-low cycles, drive cycles, anomalies.
    task automatic do_access(input bit dbg, input bit we, input logic [AW-1:0] addr,
                             input logic [DW-1:0] wd, input bit move_addr,
                             output int done_k, output int lo_cyc, output int drv_cyc, output int bad);
        done_k = 0; lo_cyc = 0; drv_cyc = 0; bad = 0;
        if (dbg) begin
            dbg_req = 1'b1; dbg_we = we; dbg_addr = addr; dbg_wdata = wd;
        end else begin
            cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
        end
        for (int k = 1; k <= 20 && done_k == 0; k++) begin
            @(posedge Clk); @(negedge Clk);
            if ((we ? Mem_WE : Mem_OE) == 1'b0) lo_cyc++;
            if ((we ? Mem_OE : Mem_WE) == 1'b0) bad++;
            if (sram_drive) begin
                drv_cyc++;
                if (Mem_WE) bad++;
            end
            if ((!Mem_OE || !Mem_WE) && (Mem_CE || Mem_UB || Mem_LB || sram_addr !== addr)) bad++;
            if (we && !Mem_WE && sram_wdata !== wd) bad++;
            if (dbg ? cpu_done : dbg_done) bad++;
            if (move_addr && k == 1) begin
                if (dbg) dbg_addr = 20'h00099; else cpu_addr = 20'h00099;
            end
            if (dbg ? dbg_done : cpu_done) begin
                done_k = k;
                cpu_req = 1'b0;
                dbg_req = 1'b0;
            end
        end
        @(posedge Clk); @(negedge Clk);
        if (cpu_done || dbg_done || !Mem_OE || !Mem_WE) bad++;
    endtask

    task automatic test_reset();
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0;
        bd_we = 0; bd_addr = '0; bd_data = '0;
`ifdef ARB_STATS_EN
        stats_clr = 1'b0;
`endif
        Reset = 1'b1;
        for (int i = 0; i < 256; i++) backdoor(8'(i), 16'hA500 ^ 16'(i * 37));
        backdoor(8'h10, 16'h1234);
        do_reset();
        n_checks++;
        if ({Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE, sram_drive} !== 6'b111110) begin
            n_fail++; $display("FAIL reset_strobes: got %b expected 111110",
                               {Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE, sram_drive});
        end
        n_checks++;
        if ({cpu_done, dbg_done} !== 2'b00) begin
            n_fail++; $display("FAIL reset_done: got %b expected 00", {cpu_done, dbg_done});
        end
        n_checks++;
        if ({cpu_rdata, dbg_rdata, sram_addr, sram_wdata} !== '0) begin
            n_fail++; $display("FAIL reset_data: got %h %h %h %h expected all zero",
                               cpu_rdata, dbg_rdata, sram_addr, sram_wdata);
        end
    endtask

    task automatic test_cpu_read();
        int dk, lo, drv, bad;
        do_access(1'b0, 1'b0, 20'h00010, 16'h0, 1'b0, dk, lo, drv, bad);
        exp_cpu_rd = ref_mem[8'h10];
        n_checks++;
        if (dk != AC + 1) begin n_fail++; $display("FAIL cpu_read_latency: got %0d expected %0d", dk, AC + 1); end
        n_checks++;
        if (lo != AC || drv != 0 || bad != 0) begin
            n_fail++; $display("FAIL cpu_read_strobes: oe_low %0d drive %0d anomalies %0d expected %0d 0 0", lo, drv, bad, AC);
        end
        n_checks++;
        if (cpu_rdata !== 16'h1234) begin n_fail++; $display("FAIL cpu_read_data: got %h expected 1234", cpu_rdata); end
        n_checks++;
        if (dbg_rdata !== exp_dbg_rd) begin n_fail++; $display("FAIL cpu_read_dbg_hold: got %h expected %h", dbg_rdata, exp_dbg_rd); end
    endtask

    task automatic test_dbg_write();
        int dk, lo, drv, bad;
        do_access(1'b1, 1'b1, 20'h00020, 16'hBEEF, 1'b0, dk, lo, drv, bad);
        ref_mem[8'h20] = 16'hBEEF;
        n_checks++;
        if (dk != AC + 1 || lo != AC || drv != AC || bad != 0) begin
            n_fail++; $display("FAIL dbg_write: done %0d we_low %0d drive %0d anomalies %0d expected %0d %0d %0d 0",
                               dk, lo, drv, bad, AC + 1, AC, AC);
        end
        n_checks++;
        if (dbg_rdata !== exp_dbg_rd || cpu_rdata !== exp_cpu_rd) begin
            n_fail++; $display("FAIL dbg_write_rdata_hold: got %h %h expected %h %h", cpu_rdata, dbg_rdata, exp_cpu_rd, exp_dbg_rd);
        end
        do_access(1'b0, 1'b0, 20'h00020, 16'h0, 1'b0, dk, lo, drv, bad);
        exp_cpu_rd = ref_mem[8'h20];
        n_checks++;
        if (cpu_rdata !== 16'hBEEF || bad != 0) begin
            n_fail++; $display("FAIL dbg_write_readback: got %h anomalies %0d expected beef 0", cpu_rdata, bad);
        end
    endtask

    task automatic test_operand_stability();
        int dk, lo, drv, bad;
        do_access(1'b0, 1'b0, 20'h00010, 16'h0, 1'b1, dk, lo, drv, bad);
        exp_cpu_rd = ref_mem[8'h10];
        n_checks++;
        if (bad != 0 || lo != AC || cpu_rdata !== exp_cpu_rd) begin
            n_fail++; $display("FAIL operand_stability: anomalies %0d oe_low %0d rdata %h expected 0 %0d %h",
                               bad, lo, cpu_rdata, AC, exp_cpu_rd);
        end
    endtask

    task automatic test_contention();
        int seen, last_k, bad;
        bit exp_dbg;
        do_reset();
        Reset = 1'b1;
        cpu_req = 1; cpu_we = 0; cpu_addr = 20'h00040;
        dbg_req = 1; dbg_we = 0; dbg_addr = 20'h00041;
        @(posedge Clk); @(negedge Clk);
        Reset = 1'b0;
        seen = 0; last_k = 0; bad = 0;
        exp_dbg = 1'b0;
        for (int k = 1; k <= 40 && seen < 4; k++) begin
            @(posedge Clk); @(negedge Clk);
            if (cpu_done && dbg_done) bad++;
            if (cpu_done || dbg_done) begin
                n_checks++;
                if (dbg_done !== exp_dbg) begin
                    n_fail++; $display("FAIL contention_order[%0d]: got dbg=%b expected dbg=%b", seen, dbg_done, exp_dbg);
                end
                n_checks++;
                if (k - last_k != (seen == 0 ? AC + 1 : AC + 2)) begin
                    n_fail++; $display("FAIL contention_spacing[%0d]: got %0d expected %0d", seen, k - last_k,
                                       (seen == 0 ? AC + 1 : AC + 2));
                end
                n_checks++;
                if ((cpu_done ? cpu_rdata : dbg_rdata) !== (cpu_done ? ref_mem[8'h40] : ref_mem[8'h41])) begin
                    n_fail++; $display("FAIL contention_data[%0d]: got %h expected %h", seen,
                                       (cpu_done ? cpu_rdata : dbg_rdata), (cpu_done ? ref_mem[8'h40] : ref_mem[8'h41]));
                end
                exp_dbg = ~exp_dbg;
                last_k = k;
                seen++;
                if (seen == 4) begin cpu_req = 0; dbg_req = 0; end
            end
        end
        exp_cpu_rd = ref_mem[8'h40];
        exp_dbg_rd = ref_mem[8'h41];
        cpu_req = 0; dbg_req = 0;
        @(posedge Clk); @(negedge Clk);
        n_checks++;
        if (seen != 4 || bad != 0) begin
            n_fail++; $display("FAIL contention_count: dones %0d simultaneous %0d expected 4 0", seen, bad);
        end
    endtask

    task automatic test_reset_mid_access();
        int dk, bad;
        cpu_req = 1; cpu_we = 0; cpu_addr = 20'h00030;
        @(posedge Clk); @(negedge Clk);
        n_checks++;
        if (Mem_OE !== 1'b0) begin n_fail++; $display("FAIL mid_reset_started: got oe %b expected 0", Mem_OE); end
        Reset = 1'b1;
        @(posedge Clk); @(negedge Clk);
        Reset = 1'b0;
        exp_cpu_rd = '0;
        exp_dbg_rd = '0;
        n_checks++;
        if ({Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE, cpu_done, dbg_done} !== 7'b1111100) begin
            n_fail++; $display("FAIL mid_reset_abort: got %b expected 1111100",
                               {Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE, cpu_done, dbg_done});
        end
        dk = 0; bad = 0;
        for (int k = 1; k <= 20 && dk == 0; k++) begin
            @(posedge Clk); @(negedge Clk);
            if (dbg_done) bad++;
            if (cpu_done) begin dk = k; cpu_req = 0; end
        end
        exp_cpu_rd = ref_mem[8'h30];
        n_checks++;
        if (dk != AC + 1 || bad != 0 || cpu_rdata !== exp_cpu_rd) begin
            n_fail++; $display("FAIL mid_reset_retry: done %0d anomalies %0d rdata %h expected %0d 0 %h",
                               dk, bad, cpu_rdata, AC + 1, exp_cpu_rd);
        end
        cpu_req = 0;
        @(posedge Clk); @(negedge Clk);
    endtask

    task automatic test_random();
        int dk, lo, drv, bad;
        bit dbg, we;
        logic [AW-1:0] a;
        logic [DW-1:0] wd;
        for (int t = 0; t < 24; t++) begin
            dbg = 1'($urandom_range(0, 1));
            we  = 1'($urandom_range(0, 1));
            a   = AW'($urandom_range(0, 255));
            wd  = DW'($urandom);
            do_access(dbg, we, a, wd, 1'b0, dk, lo, drv, bad);
            if (we) ref_mem[a[7:0]] = wd;
            else if (dbg) exp_dbg_rd = ref_mem[a[7:0]];
            else exp_cpu_rd = ref_mem[a[7:0]];
            n_checks++;
            if (dk != AC + 1 || lo != AC || drv != (we ? AC : 0) || bad != 0 ||
                cpu_rdata !== exp_cpu_rd || dbg_rdata !== exp_dbg_rd) begin
                n_fail++; $display("FAIL random[%0d] dbg=%b we=%b a=%h: done %0d low %0d drv %0d bad %0d rd %h %h expected %0d %0d %0d 0 %h %h",
                                   t, dbg, we, a, dk, lo, drv, bad, cpu_rdata, dbg_rdata,
                                   AC + 1, AC, (we ? AC : 0), exp_cpu_rd, exp_dbg_rd);
            end
        end
    endtask

`ifdef ARB_STATS_EN
    task automatic test_stats();
        int seen, dk, lo, drv, bad;
        int exp_cpu_g, exp_dbg_g;
        bit next_dbg;
        do_reset();
        n_checks++;
        if ({cpu_grants, dbg_grants, conflicts} !== '0) begin
            n_fail++; $display("FAIL stats_reset: got %0d %0d %0d expected 0 0 0", cpu_grants, dbg_grants, conflicts);
        end
        cpu_req = 1; cpu_we = 0; cpu_addr = 20'h00050;
        dbg_req = 1; dbg_we = 0; dbg_addr = 20'h00051;
        seen = 0; exp_cpu_g = 0; exp_dbg_g = 0; next_dbg = 1'b0;
        for (int k = 1; k <= 40 && seen < 3; k++) begin
            @(posedge Clk); @(negedge Clk);
            if (cpu_done || dbg_done) begin
                if (next_dbg) exp_dbg_g++; else exp_cpu_g++;
                next_dbg = ~next_dbg;
                seen++;
                if (seen == 3) begin cpu_req = 0; dbg_req = 0; end
            end
        end
        cpu_req = 0; dbg_req = 0;
        @(posedge Clk); @(negedge Clk);
        for (int i = 0; i < 2; i++) begin
            do_access(1'b0, 1'b0, 20'h00052, 16'h0, 1'b0, dk, lo, drv, bad);
            exp_cpu_g++;
        end
        n_checks++;
        if (cpu_grants !== 16'(exp_cpu_g) || dbg_grants !== 16'(exp_dbg_g) || conflicts !== 16'd3) begin
            n_fail++; $display("FAIL stats_counts: got %0d %0d %0d expected %0d %0d 3",
                               cpu_grants, dbg_grants, conflicts, exp_cpu_g, exp_dbg_g);
        end
        stats_clr = 1'b1;
        @(posedge Clk); @(negedge Clk);
        stats_clr = 1'b0;
        n_checks++;
        if ({cpu_grants, dbg_grants, conflicts} !== '0) begin
            n_fail++; $display("FAIL stats_clear: got %0d %0d %0d expected 0 0 0", cpu_grants, dbg_grants, conflicts);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_cpu_read();
        test_dbg_write();
        test_operand_stability();
        test_contention();
        test_reset_mid_access();
        test_random();
`ifdef ARB_STATS_EN
        test_stats();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Shares the single 16-bit SRAM between two requesters: the CPU memory path (MAR/MDR) and a debug/loader port that fills or inspects memory while the CPU is halted or running.
- Owns all SRAM strobes (CE/UB/LB/OE/WE) and the write-data drive enable.
- Runs each access as a fixed multi-cycle transaction behind a req/done handshake.
- Replaces the timing-by-state-count that the control unit does now.

Parameters:
- ADDR_W, 20, SRAM address width.
- DATA_W, 16, SRAM data width.
- ACCESS_CYCLES, 2, cycles each strobe is held low (legal range 1..15).

Ports:
- Clk  in  1  system clock
- Reset  in  1  synchronous, active-high reset
- cpu_req  in  1  CPU access request; held until cpu_done
- cpu_we  in  1  1=write, 0=read; stable while cpu_req is high
- cpu_addr  in  ADDR_W  CPU address (MAR)
- cpu_wdata  in  DATA_W  CPU write data (MDR)
- cpu_rdata  out  DATA_W  read data, registered; holds until the next CPU read completes
- cpu_done  out  1  one-cycle completion pulse
- dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_rdata, dbg_done: same as cpu_*, but for the debug port
- sram_rdata  in  DATA_W  data from the SRAM pins
- sram_addr  out  ADDR_W  latched access address
- sram_wdata  out  DATA_W  latched write data
- sram_drive  out  1  tristate enable for sram_wdata onto the bus
- Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE  out  1 each  SRAM strobes, all active-low
- (the ARB_STATS_EN ports are listed under Optional Feature)

Behaviour:
- States: IDLE, ACCESS, DONE. Only IDLE samples requests.
- IDLE:
  - No request: stay in IDLE.
  - Exactly one request: that port wins.
  - Both requesting: the port not in last_served wins (round-robin).
  - On the winning edge: latch winner id, we, addr and wdata into working registers; load cnt=ACCESS_CYCLES-1; go to ACCESS.
- ACCESS:
  - Mem_CE=Mem_UB=Mem_LB=0.
  - Read: Mem_OE=0, Mem_WE=1.
  - Write: Mem_WE=0, Mem_OE=1, sram_drive=1.
  - Strobes and sram_addr/sram_wdata stay constant for exactly ACCESS_CYCLES cycles.
  - cnt decrements each cycle. At cnt==0 the next edge captures sram_rdata into the winner's rdata register (reads only) and moves to DONE.
- DONE:
  - All strobes high, sram_drive=0.
  - Winner's done=1 for this one cycle; last_served<=winner; next state IDLE.
  - Requests are ignored in DONE.
- Requester contract: deassert req on the edge that ends the DONE cycle (registered response to done). A req still high in the following IDLE is treated as a new request.
- Latency: req high at edge E in IDLE -> ACCESS for cycles E+1..E+ACCESS_CYCLES -> done in cycle E+ACCESS_CYCLES+1. Back-to-back accesses issue one per ACCESS_CYCLES+2 cycles.
- Writes leave the rdata registers unchanged.
- req/we/addr/wdata changing during ACCESS have no effect (working registers are used).
- Reset values:
  - State=IDLE, last_served=DBG (so CPU wins the first tie).
  - cnt=0.
  - All strobes=1, sram_drive=0, both done=0.
  - rdata=0, sram_addr=0, sram_wdata=0.
- Reset during ACCESS: strobes go high at the next edge, no done is issued, and the aborted access is lost. A requester still holding req re-arbitrates after Reset falls.
- ACCESS_CYCLES=1: ACCESS lasts a single cycle; there is no underflow.

Optional Feature:
- Macro: ARB_STATS_EN.
- When defined, adds three outputs:
  - cpu_grants, 16-bit: increments in DONE when the winner is CPU; saturates at 16'hFFFF.
  - dbg_grants, 16-bit: same, for the debug port.
  - conflicts, 16-bit: increments on each IDLE edge where both reqs are high; saturates.
- Adds one input, stats_clr: synchronous clear with priority over increments.
- All counters reset to 0.
- When undefined: none of these ports or counters exist, and the remaining behaviour is unchanged.

Decomposition:
- Shared package sram_arb_pkg holds:
  - typedef arb_state_t {IDLE, ACCESS, DONE}
  - typedef port_id_t {PORT_CPU, PORT_DBG}
  - localparam STROBE_OFF = 1'b1
- Sub-module sat_counter (width parameter, inc, clr) is used three times under ARB_STATS_EN. Nothing else is split out.

Test Plan:
- CPU read only: SRAM model holds 16'h1234 at 20'h00010; cpu_req with we=0 -> Mem_OE low for exactly 2 cycles, cpu_done pulses at cycle 3, cpu_rdata=16'h1234, dbg_rdata unchanged.
- Debug write: dbg_we=1, addr 20'h00020, data 16'hBEEF -> Mem_WE low for 2 cycles, sram_drive high for the same 2 cycles only, dbg_done pulses once; a subsequent CPU read of 20'h00020 returns 16'hBEEF.
- Contention: both reqs held continuously from reset -> grant order CPU, DBG, CPU, DBG; each done spaced 4 cycles apart; no two dones in the same cycle.
- Operand stability: change cpu_addr during ACCESS from 20'h00010 to 20'h00099 -> sram_addr stays 20'h00010 for the whole access.
- Reset mid-access: Reset asserted in the 1st ACCESS cycle -> all strobes high next cycle, no done; after Reset falls with cpu_req still high, the access restarts and completes normally.
- ARB_STATS_EN: 3 contended plus 2 solo CPU accesses -> cpu_grants=4, dbg_grants=1 (or matching the observed grant order); conflicts counts contended IDLE edges; stats_clr zeroes all three next cycle.
